// File: rtl/data_sram_axi_bridge.sv
// Single-outstanding bridge from a core data port to AXI-Lite read/write channels.
// Every output is a flop; an optional timeout abandons a stalled bus wait with an error.
module data_sram_axi_bridge #(
  parameter int TIMEOUT_CYC = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  // state | meaning
  // IDLE  | waiting for a core request (req_ready high)
  // RD_A  | read address offered on AR
  // RD_D  | waiting for R beat
  // WR_AW | write address and data offered, each dropped on its own handshake
  // WR_B  | waiting for B response
  // RSP   | one-cycle completion pulse to the core
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, RSP} state_t;

  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam int CW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(TIMEOUT_CYC - 1) : '0;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [31:0]   araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          arvalid_q, arvalid_d, rready_q, rready_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic          waiting, timed_out;

  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    waiting     = (state_q == RD_A) || (state_q == RD_D) ||
                  (state_q == WR_AW) || (state_q == WR_B);
    timed_out   = TO_EN && (cnt_q == TO_LAST);

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          if (req_we == 4'b0000) begin
            state_d  = RD_A;
            araddr_d = {req_addr[31:2], 2'b00};
          end else begin
            state_d   = WR_AW;
            awaddr_d  = req_addr;
            wdata_d   = req_wdata;
            wstrb_d   = req_we;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      RD_A: begin
        if (arready) begin
          state_d = RD_D;
        end else if (timed_out) begin
          state_d     = RSP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end
      RD_D: begin
        if (rvalid) begin
          state_d     = RSP;
          rsp_rdata_d = rdata;
          rsp_err_d   = (rresp != 2'b00);
        end else if (timed_out) begin
          state_d     = RSP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end
      WR_AW: begin
        awvalid_d = awvalid_q && !awready;
        wvalid_d  = wvalid_q && !wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d = WR_B;
        end else if (timed_out) begin
          state_d     = RSP;
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end
      WR_B: begin
        if (bvalid) begin
          state_d     = RSP;
          rsp_rdata_d = '0;
          rsp_err_d   = (bresp != 2'b00);
        end else if (timed_out) begin
          state_d     = RSP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state wants on the pins.
    req_ready_d = (state_d == IDLE);
    arvalid_d   = (state_d == RD_A);
    rready_d    = (state_d == RD_D);
    bready_d    = (state_d == WR_B);
    rsp_valid_d = (state_d == RSP);

    if ((state_d != state_q) || !waiting || !TO_EN) cnt_d = '0;
    else                                            cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      araddr_q    <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      araddr_q    <= araddr_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign araddr    = araddr_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign awaddr    = awaddr_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Directed bench for data_sram_axi_bridge with TIMEOUT_CYC=8; each task checks its
// own hand-computed expectations one sample #1 after the rising edge.
module tb_data_sram_axi_bridge;

  logic        clk, resetn;
  logic        req_valid, req_ready;
  logic [3:0]  req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int n_vec = 0;
  int n_mis = 0;

  data_sram_axi_bridge #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_slave();
    arready = 0; rvalid = 0; rdata = '0; rresp = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0;
  endtask

  task automatic test_reset();
    resetn = 1; req_valid = 0; req_we = '0; req_addr = '0; req_wdata = '0;
    idle_slave();
    #2 resetn = 0;
    step(); step();
    n_vec++;
    if ({req_ready, arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err} !== 8'h00) begin
      $display("FAIL reset_ctl: got %b want 00000000",
               {req_ready, arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err});
      n_mis++;
    end
    n_vec++;
    if ({araddr, awaddr, wdata, wstrb, rsp_rdata} !== '0) begin
      $display("FAIL reset_data: araddr=%h awaddr=%h wdata=%h wstrb=%h rdata=%h want all 0",
               araddr, awaddr, wdata, wstrb, rsp_rdata);
      n_mis++;
    end
    resetn = 1;
    n_vec++;
    if (req_ready !== 1'b0) begin
      $display("FAIL reset_release_ready: got %b want 0 before first clock", req_ready);
      n_mis++;
    end
    step();
    n_vec++;
    if (req_ready !== 1'b1) begin
      $display("FAIL reset_first_clk_ready: got %b want 1", req_ready);
      n_mis++;
    end
  endtask

  task automatic test_read_basic();
    req_valid = 1; req_we = 4'b0000; req_addr = 32'h1C00_0004;
    arready = 1; rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    step();
    req_valid = 0;
    n_vec++;
    if ({req_ready, arvalid, araddr} !== {1'b0, 1'b1, 32'h1C00_0004}) begin
      $display("FAIL rd_addr: ready=%b arvalid=%b araddr=%h want 0 1 1c000004", req_ready, arvalid, araddr);
      n_mis++;
    end
    step();
    n_vec++;
    if ({arvalid, rready, rsp_valid} !== 3'b010) begin
      $display("FAIL rd_data_phase: arvalid,rready,rsp_valid=%b want 010", {arvalid, rready, rsp_valid});
      n_mis++;
    end
    step();
    n_vec++;
    if ({rsp_valid, rsp_err, rsp_rdata, rready} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
      $display("FAIL rd_rsp: valid=%b err=%b rdata=%h rready=%b want 1 0 deadbeef 0",
               rsp_valid, rsp_err, rsp_rdata, rready);
      n_mis++;
    end
    step();
    n_vec++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      $display("FAIL rd_back_idle: rsp_valid,req_ready=%b want 01", {rsp_valid, req_ready});
      n_mis++;
    end
    idle_slave();
  endtask

  task automatic test_read_err();
    req_valid = 1; req_we = 4'b0000; req_addr = 32'h2000_0003;
    step();
    req_valid = 0;
    n_vec++;
    if (araddr !== 32'h2000_0000) begin
      $display("FAIL rd_align: araddr=%h want 20000000", araddr);
      n_mis++;
    end
    step();
    n_vec++;
    if (arvalid !== 1'b1) begin
      $display("FAIL rd_ar_hold: arvalid=%b want 1 while arready low", arvalid);
      n_mis++;
    end
    arready = 1;
    step();
    arready = 0; rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'b10;
    step();
    rvalid = 0;
    n_vec++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'hCAFE_F00D}) begin
      $display("FAIL rd_slverr: valid=%b err=%b rdata=%h want 1 1 cafef00d", rsp_valid, rsp_err, rsp_rdata);
      n_mis++;
    end
    step();
    idle_slave();
  endtask

  task automatic test_write_skew();
    req_valid = 1; req_we = 4'b0011; req_addr = 32'h0000_0100; req_wdata = 32'h1234_5678;
    step();
    req_valid = 0;
    n_vec++;
    if ({awvalid, wvalid, wstrb, awaddr, wdata} !== {1'b1, 1'b1, 4'b0011, 32'h100, 32'h1234_5678}) begin
      $display("FAIL wr_offer: awv=%b wv=%b wstrb=%b awaddr=%h wdata=%h want 1 1 0011 100 12345678",
               awvalid, wvalid, wstrb, awaddr, wdata);
      n_mis++;
    end
    awready = 1;
    step();
    awready = 0;
    n_vec++;
    if ({awvalid, wvalid, bready} !== 3'b010) begin
      $display("FAIL wr_aw_first: awv,wv,bready=%b want 010", {awvalid, wvalid, bready});
      n_mis++;
    end
    step();
    n_vec++;
    if ({awvalid, wvalid, wdata, wstrb} !== {1'b0, 1'b1, 32'h1234_5678, 4'b0011}) begin
      $display("FAIL wr_w_hold: awv=%b wv=%b wdata=%h wstrb=%b want 0 1 12345678 0011",
               awvalid, wvalid, wdata, wstrb);
      n_mis++;
    end
    wready = 1;
    step();
    wready = 0;
    n_vec++;
    if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
      $display("FAIL wr_to_b: awv,wv,bready,rsp_valid=%b want 0010", {awvalid, wvalid, bready, rsp_valid});
      n_mis++;
    end
    step();
    n_vec++;
    if ({bready, rsp_valid} !== 2'b10) begin
      $display("FAIL wr_b_wait: bready,rsp_valid=%b want 10", {bready, rsp_valid});
      n_mis++;
    end
    bvalid = 1; bresp = 2'b00;
    step();
    bvalid = 0;
    n_vec++;
    if ({rsp_valid, rsp_err, rsp_rdata, bready} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      $display("FAIL wr_rsp: valid=%b err=%b rdata=%h bready=%b want 1 0 0 0", rsp_valid, rsp_err, rsp_rdata, bready);
      n_mis++;
    end
    step();
    n_vec++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      $display("FAIL wr_single_rsp: rsp_valid,req_ready=%b want 01", {rsp_valid, req_ready});
      n_mis++;
    end
    idle_slave();
  endtask

  task automatic test_timeout();
    int bad = 0;
    req_valid = 1; req_we = 4'b0000; req_addr = 32'h0000_0040;
    step();
    req_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      if ({arvalid, rsp_valid} !== 2'b10) bad++;
      step();
    end
    n_vec++;
    if (bad != 0) begin
      $display("FAIL to_wait: %0d of 8 wait cycles without arvalid=1 rsp_valid=0, want 0", bad);
      n_mis++;
    end
    n_vec++;
    if ({rsp_valid, rsp_err, rsp_rdata, arvalid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      $display("FAIL to_rsp_cycle9: valid=%b err=%b rdata=%h arvalid=%b want 1 1 0 0",
               rsp_valid, rsp_err, rsp_rdata, arvalid);
      n_mis++;
    end
    step();
    n_vec++;
    if ({rsp_valid, req_ready, arvalid} !== 3'b010) begin
      $display("FAIL to_back_idle: rsp_valid,req_ready,arvalid=%b want 010", {rsp_valid, req_ready, arvalid});
      n_mis++;
    end
  endtask

  task automatic test_back_to_back();
    // cycles 1..7 after first accept: read then write with req_valid held high
    logic [6:0] exp_ready, exp_rsp, exp_ar, exp_aw;
    logic [6:0] got_ready, got_rsp, got_ar, got_aw;
    exp_ready = 7'b0001000;   // bit k-1 = cycle k
    exp_rsp   = 7'b1000100;
    exp_ar    = 7'b0000001;
    exp_aw    = 7'b0010000;
    got_ready = '0; got_rsp = '0; got_ar = '0; got_aw = '0;
    arready = 1; rvalid = 1; rdata = 32'h1111_1111; rresp = 2'b00;
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b10;
    req_valid = 1; req_we = 4'b0000; req_addr = 32'h0000_0200;
    step();
    req_we = 4'b1111; req_addr = 32'h0000_0300; req_wdata = 32'hA5A5_5A5A;
    for (int k = 1; k <= 7; k++) begin
      got_ready[k-1] = req_ready;
      got_rsp[k-1]   = rsp_valid;
      got_ar[k-1]    = arvalid;
      got_aw[k-1]    = awvalid;
      if (k == 3) begin
        n_vec++;
        if ({rsp_rdata, rsp_err} !== {32'h1111_1111, 1'b0}) begin
          $display("FAIL b2b_rd_rsp: rdata=%h err=%b want 11111111 0", rsp_rdata, rsp_err);
          n_mis++;
        end
      end
      if (k == 5) req_valid = 0;
      if (k == 7) begin
        n_vec++;
        if ({rsp_rdata, rsp_err} !== {32'h0, 1'b1}) begin
          $display("FAIL b2b_wr_rsp: rdata=%h err=%b want 0 1", rsp_rdata, rsp_err);
          n_mis++;
        end
      end
      step();
    end
    n_vec++;
    if ({got_ready, got_rsp} !== {exp_ready, exp_rsp}) begin
      $display("FAIL b2b_ready_rsp: ready=%b rsp=%b want %b %b", got_ready, got_rsp, exp_ready, exp_rsp);
      n_mis++;
    end
    n_vec++;
    if ({got_ar, got_aw} !== {exp_ar, exp_aw}) begin
      $display("FAIL b2b_bus: arvalid=%b awvalid=%b want %b %b", got_ar, got_aw, exp_ar, exp_aw);
      n_mis++;
    end
    n_vec++;
    if ({req_ready, rsp_valid, awvalid, arvalid} !== 4'b1000) begin
      $display("FAIL b2b_end_idle: ready,rsp,awv,arv=%b want 1000", {req_ready, rsp_valid, awvalid, arvalid});
      n_mis++;
    end
    idle_slave();
  endtask

  task automatic test_reset_mid();
    int seen_rsp = 0;
    req_valid = 1; req_we = 4'b1100; req_addr = 32'h0000_0444; req_wdata = 32'h0BAD_F00D;
    awready = 1; wready = 1;
    step();
    req_valid = 0;
    step();
    awready = 0; wready = 0;
    n_vec++;
    if (bready !== 1'b1) begin
      $display("FAIL rst_mid_in_wr_b: bready=%b want 1", bready);
      n_mis++;
    end
    resetn = 0;
    #1;
    n_vec++;
    if ({req_ready, arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err} !== 8'h00 ||
        {araddr, awaddr, wdata, wstrb, rsp_rdata} !== '0) begin
      $display("FAIL rst_mid_async: ctl=%b awaddr=%h wdata=%h wstrb=%b want all 0",
               {req_ready, arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err}, awaddr, wdata, wstrb);
      n_mis++;
    end
    bvalid = 1;
    step();
    if (rsp_valid !== 1'b0) seen_rsp++;
    step();
    if (rsp_valid !== 1'b0) seen_rsp++;
    resetn = 1;
    step();
    bvalid = 0;
    if (rsp_valid !== 1'b0) seen_rsp++;
    n_vec++;
    if (seen_rsp != 0) begin
      $display("FAIL rst_mid_no_rsp: rsp_valid seen %0d times, want 0", seen_rsp);
      n_mis++;
    end
    n_vec++;
    if ({req_ready, bready} !== 2'b10) begin
      $display("FAIL rst_mid_release: req_ready,bready=%b want 10", {req_ready, bready});
      n_mis++;
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_read_err();
    test_write_skew();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
